// File: rtl/muladd_rtn_queue_pkg.sv
// Shared widths and error-bit indices for the multiply-add return queue.
package muladd_rtn_queue_pkg;

    localparam int RES_W_DEF  = 64;
    localparam int HTID_W_DEF = 9;
    localparam int ERR_W      = 2;
    localparam int ERR_OVF    = 0;
    localparam int ERR_NOCRED = 1;

endpackage

// File: rtl/muladd_rtn_queue_if.sv
// Result stream bundle: vld/res/ht_id travel downstream and rdy travels upstream.
// Handshake: a transfer happens in a cycle where vld & rdy are both high; vld must not depend on rdy.
interface muladd_rtn_queue_if
    import muladd_rtn_queue_pkg::*;
#(
    parameter int RES_W  = RES_W_DEF,
    parameter int HTID_W = HTID_W_DEF
);

    logic              vld;
    logic              rdy;
    logic [RES_W-1:0]  res;
    logic [HTID_W-1:0] ht_id;

    modport master (output vld, output res, output ht_id, input  rdy);
    modport slave  (input  vld, input  res, input  ht_id, output rdy);

endinterface

// File: rtl/muladd_rtn_queue_ram.sv
// Result storage: one synchronous write port, one asynchronous read port.
module muladd_rtn_queue_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 73
) (
    input  logic                     ck,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge ck) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/muladd_rtn_queue.sv
// Return stage for the multiply-add unit: buffers the non-stallable result stream
// and withholds issue credit so every in-flight result is guaranteed a slot.
module muladd_rtn_queue
    import muladd_rtn_queue_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int RES_W  = RES_W_DEF,
    parameter int HTID_W = HTID_W_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                ck,
    input  logic                rst_n,
    input  logic                i_issue,
    input  logic                i_mad_rdy,
    output logic                o_issue_ok,
    muladd_rtn_queue_if.slave   i_push,
    muladd_rtn_queue_if.master  o_pop,
    output logic [CNT_W-1:0]    o_inflight,
    output logic [CNT_W-1:0]    o_count,
    output logic [ERR_W-1:0]    o_err
);

    localparam int              PTR_W = $clog2(DEPTH);
    localparam int              ENT_W = RES_W + HTID_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_inflight;
    logic [ERR_W-1:0] r_err;

    logic             w_head_vld;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic             w_nocred;
    logic [ENT_W-1:0] w_rdata;

    // Full/empty come from the occupancy count; pointers alone are ambiguous when equal.
    assign w_head_vld = (r_count != '0);
    assign w_full     = (r_count == FULL);
    assign w_pop      = w_head_vld & o_pop.rdy;
    assign w_push     = i_push.vld & (~w_full | w_pop);
    assign w_ovf      = i_push.vld & w_full & ~w_pop;
    assign w_nocred   = i_issue & (r_inflight == FULL);

    muladd_rtn_queue_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ram (
        .ck      (ck),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_push.res, i_push.ht_id}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Credit saturates at both ends instead of wrapping on misuse.
            if (i_issue && !w_pop && (r_inflight != FULL)) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!i_issue && w_pop && (r_inflight != '0)) begin
                r_inflight <= r_inflight - 1'b1;
            end

            if (w_ovf) begin
                r_err[ERR_OVF] <= 1'b1;
            end
            if (w_nocred) begin
                r_err[ERR_NOCRED] <= 1'b1;
            end
        end
    end

    // The result stream cannot be stalled, so the push side is always ready.
    assign i_push.rdy  = 1'b1;
    assign o_pop.vld   = w_head_vld;
    assign o_pop.res   = w_rdata[ENT_W-1:HTID_W];
    assign o_pop.ht_id = w_rdata[HTID_W-1:0];

    assign o_issue_ok  = i_mad_rdy & (r_inflight < FULL);
    assign o_inflight  = r_inflight;
    assign o_count     = r_count;
    assign o_err       = r_err;

endmodule

// File: tb/tb_muladd_rtn_queue.sv
// Directed bench for muladd_rtn_queue: a vector table for the basic flow plus
// hand-written sequences for fill, overflow, wrap-around and async reset.
module tb_muladd_rtn_queue;
    import muladd_rtn_queue_pkg::*;

    localparam int DEPTH  = 32;
    localparam int RES_W  = 64;
    localparam int HTID_W = 9;
    localparam int CNT_W  = 6;

    logic             ck = 1'b0;
    logic             rst_n = 1'b1;
    logic             i_issue = 1'b0;
    logic             i_mad_rdy = 1'b0;
    logic             o_issue_ok;
    logic [CNT_W-1:0] o_inflight;
    logic [CNT_W-1:0] o_count;
    logic [1:0]       o_err;

    muladd_rtn_queue_if #(.RES_W(RES_W), .HTID_W(HTID_W)) push_if ();
    muladd_rtn_queue_if #(.RES_W(RES_W), .HTID_W(HTID_W)) pop_if ();

    muladd_rtn_queue #(
        .DEPTH  (DEPTH),
        .RES_W  (RES_W),
        .HTID_W (HTID_W),
        .CNT_W  (CNT_W)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .i_issue    (i_issue),
        .i_mad_rdy  (i_mad_rdy),
        .o_issue_ok (o_issue_ok),
        .i_push     (push_if),
        .o_pop      (pop_if),
        .o_inflight (o_inflight),
        .o_count    (o_count),
        .o_err      (o_err)
    );

    // ---------------- clock ----------------
    always #5 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [RES_W+HTID_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic e_vld, input logic [CNT_W-1:0] e_cnt,
                             input logic [CNT_W-1:0] e_infl, input logic e_ok, input logic [1:0] e_err);
        chk({tag, "_vld"},  64'(pop_if.vld), 64'(e_vld));
        chk({tag, "_cnt"},  64'(o_count),    64'(e_cnt));
        chk({tag, "_infl"}, 64'(o_inflight), 64'(e_infl));
        chk({tag, "_ok"},   64'(o_issue_ok), 64'(e_ok));
        chk({tag, "_err"},  64'(o_err),      64'(e_err));
    endtask

    task automatic chk_head(input string tag, input logic [RES_W-1:0] e_res, input logic [HTID_W-1:0] e_ht);
        chk({tag, "_res"}, pop_if.res, e_res);
        chk({tag, "_ht"},  64'(pop_if.ht_id), 64'(e_ht));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic drive(input logic issue, input logic mad, input logic vld,
                         input logic [RES_W-1:0] res, input logic [HTID_W-1:0] ht, input logic rdy);
        i_issue       = issue;
        i_mad_rdy     = mad;
        push_if.vld   = vld;
        push_if.res   = res;
        push_if.ht_id = ht;
        pop_if.rdy    = rdy;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              issue;
        logic              vld;
        logic [RES_W-1:0]  res;
        logic [HTID_W-1:0] ht;
        logic              rdy;
        logic              e_vld;
        logic [RES_W-1:0]  e_res;
        logic [HTID_W-1:0] e_ht;
        logic [CNT_W-1:0]  e_infl;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n_push;
        int n_pop;
        int cyc;
        logic rdy_b;
        logic vld_b;
        logic pop_b;
        logic full_b;

        vt[0] = '{1'b1, 1'b0, 64'h0, 9'd0, 1'b1, 1'b0, 64'h0, 9'd0, 6'd1, 6'd0};
        vt[1] = '{1'b1, 1'b0, 64'h0, 9'd0, 1'b1, 1'b0, 64'h0, 9'd0, 6'd2, 6'd0};
        vt[2] = '{1'b1, 1'b0, 64'h0, 9'd0, 1'b1, 1'b0, 64'h0, 9'd0, 6'd3, 6'd0};
        vt[3] = '{1'b0, 1'b1, 64'h3FF0000000000000, 9'd5, 1'b1,
                  1'b1, 64'h3FF0000000000000, 9'd5, 6'd3, 6'd1};
        vt[4] = '{1'b0, 1'b1, 64'h4000000000000000, 9'd6, 1'b1,
                  1'b1, 64'h4000000000000000, 9'd6, 6'd2, 6'd1};
        vt[5] = '{1'b0, 1'b1, 64'h4008000000000000, 9'd7, 1'b1,
                  1'b1, 64'h4008000000000000, 9'd7, 6'd1, 6'd1};
        vt[6] = '{1'b0, 1'b0, 64'h0, 9'd0, 1'b1, 1'b0, 64'h0, 9'd0, 6'd0, 6'd0};

        // ---------------- reset ----------------
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_state("rst", 1'b0, 6'd0, 6'd0, 1'b1, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;

        // ---------------- basic flow from the table ----------------
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].issue, 1'b1, vt[i].vld, vt[i].res, vt[i].ht, vt[i].rdy);
            tick();
            chk_state($sformatf("v%0d", i), vt[i].e_vld, vt[i].e_cnt, vt[i].e_infl, 1'b1, 2'b00);
            if (vt[i].e_vld) chk_head($sformatf("v%0d", i), vt[i].e_res, vt[i].e_ht);
        end

        // ---------------- fill credit and buffer ----------------
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk("fill_infl", 64'(o_inflight), 64'(k + 1));
            chk("fill_ok", 64'(o_issue_ok), 64'(k < DEPTH - 1));
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b1, 1'b1, 64'h5000 + 64'(k), 9'(100 + k), 1'b0);
            tick();
        end
        chk_state("full", 1'b1, 6'd32, 6'd32, 1'b0, 2'b00);
        chk_head("full", 64'h5000, 9'd100);

        // issue without credit
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        chk_state("nocred", 1'b1, 6'd32, 6'd32, 1'b0, 2'b10);

        // push into a full buffer with no pop is dropped
        drive(1'b0, 1'b1, 1'b1, 64'hDEAD, 9'h1FF, 1'b0);
        tick();
        chk_state("ovf", 1'b1, 6'd32, 6'd32, 1'b0, 2'b11);
        chk_head("ovf", 64'h5000, 9'd100);

        // push with simultaneous pop into a full buffer is accepted
        drive(1'b0, 1'b1, 1'b1, 64'hAAAA, 9'd200, 1'b1);
        tick();
        chk_state("fullpp", 1'b1, 6'd32, 6'd31, 1'b1, 2'b11);
        chk_head("fullpp", 64'h5001, 9'd101);

        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        for (int j = 1; j <= 31; j++) begin
            tick();
            chk("drain_cnt", 64'(o_count), 64'(32 - j));
            if (j < 31) chk_head("drain", 64'h5001 + 64'(j), 9'(101 + j));
            else        chk_head("drain_new", 64'hAAAA, 9'd200);
        end
        tick();
        chk("empty_vld", 64'(pop_if.vld), 64'd0);
        chk("empty_cnt", 64'(o_count), 64'd0);

        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_err", 64'(o_err), 64'd0);

        // ---------------- streaming with wrap ----------------
        n_push = 0;
        n_pop  = 0;
        cyc    = 0;
        exp_q.delete();
        while (!(n_push == 100 && exp_q.size() == 0) && cyc < 400) begin
            rdy_b  = (cyc % 2 == 0);
            vld_b  = (cyc % 3 != 2) && (n_push < 100);
            pop_b  = (exp_q.size() != 0) && rdy_b;
            full_b = (exp_q.size() == DEPTH);
            drive(1'b0, 1'b1, vld_b, 64'hC000000000000000 | 64'(n_push), 9'(n_push), rdy_b);
            tick();
            if (pop_b) begin
                void'(exp_q.pop_front());
                n_pop++;
            end
            if (vld_b && (!full_b || pop_b)) exp_q.push_back({64'hC000000000000000 | 64'(n_push), 9'(n_push)});
            if (vld_b) n_push++;
            chk("strm_vld", 64'(pop_if.vld), 64'(exp_q.size() != 0));
            chk("strm_cnt", 64'(o_count), 64'(exp_q.size()));
            if (exp_q.size() != 0) chk_head("strm", exp_q[0][RES_W+HTID_W-1:HTID_W], exp_q[0][HTID_W-1:0]);
            cyc++;
        end
        n_vec++;
        if (cyc >= 400) begin
            n_err++;
            $display("FAIL strm_timeout: got %0d cycles, want under 400", cyc);
        end
        chk("strm_npop", 64'(n_pop), 64'd100);
        chk("strm_err", 64'(o_err), 64'd0);

        // ---------------- async reset mid-stream ----------------
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b1, 64'h7000 + 64'(k), 9'(k), 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        chk_state("pre_rst", 1'b1, 6'd10, 6'd32, 1'b0, 2'b10);
        chk_head("pre_rst", 64'h7000, 9'd0);
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 6'd0, 6'd0, 1'b1, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("post_rst", 1'b0, 6'd0, 6'd0, 1'b1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
